// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader that fills program memory and then releases the core
module program_loader #(
  parameter int ADDR_W = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN0 = 3'd1;
  localparam logic [2:0] LEN1 = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [31:0] word;
  logic        acc;
  assign in_ready = state != DONE && state != ERR;
  assign cpu_hold = state != DONE;
  assign done     = state == DONE;
  assign error    = state == ERR;
  assign acc      = in_valid && in_ready;
  // frame parser: header, little-endian word assembly with one-cycle write strobe, checksum verdict
  always_ff @(posedge clk) begin
    mem_we <= 1'b0;
    if (!rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      len       <= '0;
      csum      <= '0;
      word      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if ((state == DONE || state == ERR) && start) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      len      <= '0;
      csum     <= '0;
      word     <= '0;
    end else if (acc) begin
      case (state)
        IDLE: state <= in_data == SYNC_BYTE ? LEN0 : IDLE;
        LEN0: begin
          len[7:0] <= in_data;
          state    <= LEN1;
        end
        LEN1: begin
          len[15:8] <= in_data;
          state     <= {1'b0, in_data, len[7:0]} > DEPTH ? ERR :
                       {in_data, len[7:0]} == 16'd0 ? CSUM : DATA;
        end
        DATA: begin
          word[{byte_cnt, 3'b000} +: 8] <= in_data;
          csum     <= csum ^ in_data;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_cnt[ADDR_W-1:0];
            mem_wdata <= {in_data, word[23:0]};
            word_cnt  <= word_cnt + 16'd1;
            if (word_cnt + 16'd1 == len) state <= CSUM;
          end
        end
        CSUM: state <= in_data == csum ? DONE : ERR;
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  int checks = 0;
  int errors = 0;
  int nw = 0;
  logic [7:0]  wa [0:299];
  logic [31:0] wd [0:299];
  logic [7:0]  good [0:11];
  logic [7:0]  cs;
  logic [31:0] w;

  program_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // log every write strobe away from the active edge
  always @(negedge clk) begin
    if (mem_we === 1'b1 && nw < 300) begin
      wa[nw] = mem_addr;
      wd[nw] = mem_wdata;
      nw++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    send(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nw"}, 32'(nw), 32'd2);
    chk({tag, "_a0"}, {24'd0, wa[0]}, 32'd0);
    chk({tag, "_d0"}, wd[0], 32'h00500093);
    chk({tag, "_a1"}, {24'd0, wa[1]}, 32'd1);
    chk({tag, "_d1"}, wd[1], 32'h00A00113);
  endtask

  initial begin
    good = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // good frame, one byte per cycle, with exact write latency
    nw = 0;
    for (int i = 0; i < 6; i++) send(good[i]);
    chk("g_we_pre", {31'd0, mem_we}, 32'd0);
    send(good[6]);
    chk("g_we0", {31'd0, mem_we}, 32'd1);
    chk("g_addr0", {24'd0, mem_addr}, 32'd0);
    chk("g_wdata0", mem_wdata, 32'h00500093);
    send(good[7]);
    chk("g_we_off", {31'd0, mem_we}, 32'd0);
    send(good[8]); send(good[9]); send(good[10]);
    chk("g_we1", {31'd0, mem_we}, 32'd1);
    chk("g_addr1", {24'd0, mem_addr}, 32'd1);
    chk("g_wdata1", mem_wdata, 32'h00A00113);
    chk("g_hold_csum", {31'd0, cpu_hold}, 32'd1);
    send(good[11]);
    chk("g_done", {31'd0, done}, 32'd1);
    chk("g_hold", {31'd0, cpu_hold}, 32'd0);
    chk("g_ready", {31'd0, in_ready}, 32'd0);
    chk("g_error", {31'd0, error}, 32'd0);
    send(8'hA5);
    chk("g_ready_after", {31'd0, in_ready}, 32'd0);
    check_two_writes("g");
    pulse_start();
    chk("g_st_done", {31'd0, done}, 32'd0);
    chk("g_st_hold", {31'd0, cpu_hold}, 32'd1);
    chk("g_st_ready", {31'd0, in_ready}, 32'd1);
    // junk bytes ahead of the frame are discarded
    nw = 0;
    send(8'h00); send(8'hFF); send(8'h12);
    for (int i = 0; i < 12; i++) send(good[i]);
    check_two_writes("j");
    chk("j_done", {31'd0, done}, 32'd1);
    pulse_start();
    // bad checksum: writes happen, frame rejected
    nw = 0;
    for (int i = 0; i < 11; i++) send(good[i]);
    send(8'h70);
    check_two_writes("b");
    chk("b_error", {31'd0, error}, 32'd1);
    chk("b_hold", {31'd0, cpu_hold}, 32'd1);
    chk("b_done", {31'd0, done}, 32'd0);
    chk("b_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    chk("b_st_error", {31'd0, error}, 32'd0);
    chk("b_st_ready", {31'd0, in_ready}, 32'd1);
    // oversize length 257 rejected right after LEN_HI
    nw = 0;
    send(8'hA5); send(8'h01); send(8'h01);
    chk("o_error", {31'd0, error}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("o_nw", 32'(nw), 32'd0);
    pulse_start();
    // length 256 fills the whole memory
    nw = 0;
    cs = 8'h00;
    send(8'hA5); send(8'h00); send(8'h01);
    chk("m_error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'(i * 3), 8'h5A};
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send(w[8*k +: 8]);
      end
    end
    send(cs);
    chk("m_done", {31'd0, done}, 32'd1);
    chk("m_nw", 32'(nw), 32'd256);
    chk("m_a0", {24'd0, wa[0]}, 32'd0);
    chk("m_d0", wd[0], 32'h00FF005A);
    chk("m_a255", {24'd0, wa[255]}, 32'd255);
    chk("m_d255", wd[255], 32'hFF00FD5A);
    pulse_start();
    // zero-length frames
    nw = 0;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_nw", 32'(nw), 32'd0);
    pulse_start();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
    chk("z_error", {31'd0, error}, 32'd1);
    chk("z_done_bad", {31'd0, done}, 32'd0);
    pulse_start();
    // throttled frame; a start pulse mid-frame is ignored
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) pulse_start();
      send_gap(good[i], int'($urandom_range(0, 3)));
    end
    check_two_writes("t");
    chk("t_done", {31'd0, done}, 32'd1);
    pulse_start();
    // reset lands on the edge that accepts the fourth byte of word 0
    nw = 0;
    for (int i = 0; i < 6; i++) send(good[i]);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = good[6];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("r_we", {31'd0, mem_we}, 32'd0);
    chk("r_ready", {31'd0, in_ready}, 32'd1);
    chk("r_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("r_nw", 32'(nw), 32'd0);
    for (int i = 0; i < 12; i++) send(good[i]);
    check_two_writes("r");
    chk("r_done", {31'd0, done}, 32'd1);
    chk("r_hold_rel", {31'd0, cpu_hold}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader that writes the instruction memory of RISCV_Processor in place of the simulation-only file preload.
- Receives a framed image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes each word to program memory at sequential word addresses.
- Holds the core in reset until a frame loads cleanly, then releases it.

Parameters:
- ADDR_W, 8, program memory word-address width; depth = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle strobe; from DONE or ERR, returns to IDLE and re-asserts cpu_hold.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  program memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for mem_we.
- mem_wdata  out  32  word data for mem_we.
- cpu_hold  out  1  drives processor reset; 1 = core held.
- done  out  1  sticky, frame loaded and checksum good.
- error  out  1  sticky, frame rejected.

Behaviour:
- Byte acceptance: a byte is accepted on a posedge where in_valid && in_ready.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then N = {LEN_HI,LEN_LO} words of 4 bytes each (LSB first), then CSUM.
- CSUM = XOR of all data bytes only; sync and length bytes are excluded.
- Reset (rst==0 at posedge) values:
  - state=IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0.
  - cpu_hold=1; done=0; error=0.
  - Internal byte counter, word counter, length and checksum all 0.
- State transitions (on an accepted byte unless noted):
  - IDLE: SYNC_BYTE -> LEN0; any other byte is discarded and the state stays IDLE.
  - LEN0: latch LEN_LO -> LEN1.
  - LEN1: latch LEN_HI, then:
    - N > 2**ADDR_W -> ERR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: shift the byte into the word register at position byte_cnt (0..3) and XOR it into the checksum.
    - On the 4th byte: next cycle mem_we=1, mem_wdata=assembled word, mem_addr=word_cnt; then word_cnt increments.
    - After word N-1's 4th byte -> CSUM.
  - CSUM: byte == running checksum -> DONE; otherwise -> ERR.
  - DONE: in_ready=0, done=1, cpu_hold=0 from the cycle after the CSUM byte is accepted.
  - ERR: in_ready=0, error=1, cpu_hold stays 1.
  - DONE/ERR + start: -> IDLE next cycle; done=0, error=0, cpu_hold=1, counters and checksum cleared.
  - start is ignored in states IDLE through CSUM.
- mem_we latency:
  - Asserted exactly one cycle after the accepting edge of a word's 4th byte, for exactly one cycle.
  - Never asserted outside DATA-induced writes.
  - Back-to-back bytes may produce mem_we on consecutive words spaced ≥4 cycles apart.
- in_ready:
  - Combinational from state: 1 in IDLE, LEN0, LEN1, DATA, CSUM; 0 in DONE, ERR.
  - No stall during a write cycle.
- in_valid low: no state change; partial words are retained indefinitely.
- Address wrap cannot occur: N is bounded by the length check. When N == 2**ADDR_W, the last write uses address 2**ADDR_W-1.
- No rollback: on ERR, words already written stay in memory, but the core remains held.
- Reset mid-frame:
  - Returns to IDLE on that edge.
  - A pending mem_we for that cycle is suppressed.
  - Memory is not cleared.
- Simultaneous rst==0 and start: reset wins.

Test Plan:
- Good frame A5 02 00 93 00 50 00 13 01 A0 00 71, one byte per cycle:
  - mem_we at addr 0 with 32'h00500093, then at addr 1 with 32'h00A00113.
  - done=1 and cpu_hold=0 one cycle after 71 is accepted.
  - in_ready=0 thereafter.
- Junk then frame: 00 FF 12 preceding the frame above -> junk ignored, identical writes and done=1.
- Bad checksum: same frame ending 70 instead of 71:
  - Both writes still occur.
  - error=1, cpu_hold=1, done=0.
  - start pulse -> IDLE, error=0, in_ready=1.
- Oversize length with ADDR_W=8: A5 01 01 (N=257) -> ERR immediately after LEN_HI, no mem_we; A5 00 01 (N=256) accepted.
- Zero length: A5 00 00 00 -> done=1 with no mem_we; A5 00 00 01 -> error=1.
- Throttle and reset:
  - Random in_valid gaps on the good frame -> identical writes and values.
  - rst=0 after byte 93 50 (mid-word) -> no mem_we; state IDLE, cpu_hold=1.
  - Resending the full frame then loads correctly.
